gpio_bank: RTL and testbench
============================

# gpio_bank

Parametrised general-purpose I/O bank. It replaces the fixed 16-pin, write-only, one-bit-per-address GPIO controller. It adds:
- a programmable direction per pin;
- word-wide set, clear and toggle writes;
- synchronised input readback;
- edge-triggered interrupts with a write-1-to-clear status register.

The bank sits on the memory-mapped peripheral bus beside the other MieruPC I/O controllers and drives the board pins directly.

## Interface
- `NPIN`, 16: number of pins, 1..32; sets the data-path width.
- `AW`, 32: address bus width.
- `BASE`, 'h8001f0: bank base address; bits [3:0] must be 0.
- `CLK` in, 1: system clock.
- `RST_X` in, 1: asynchronous, active-low reset.
- `WE` in, 1: write strobe, sampled at posedge.
- `RE` in, 1: read strobe, sampled at posedge.
- `ADDR` in, AW: byte address of the access.
- `WDATA` in, NPIN: write data.
- `RDATA` out, NPIN: read data, registered.
- `RVALID` out, 1: one-cycle pulse that qualifies `RDATA`.
- `IRQ` out, 1: level interrupt, high while any pin has both status and enable set.
- `GPIO` inout, NPIN: pins. Bit i is driven from `OUT[i]` when `DIR[i]`=1; otherwise it is high-Z.

## Operation
- **Hit:** `ADDR[AW-1:4] == BASE[AW-1:4]`. Offset = `ADDR[3:0]`.
- **Register map (offset: name, access):**
  - 0: `OUT`, RW
  - 1: `DIR`, RW; 1 = output
  - 2: `IN`, RO; synchronised pin level
  - 3: `SET`, WO; `OUT |= WDATA`
  - 4: `CLR`, WO; `OUT &= ~WDATA`
  - 5: `TOG`, WO; `OUT ^= WDATA`
  - 6: `IER`, RW; rising-edge interrupt enable
  - 7: `IEF`, RW; falling-edge interrupt enable
  - 8: `ISR`, RW1C; edge status
  - 9-15: reserved; reads return 0, writes are ignored.
- **Write-only offsets:** reads of `SET`, `CLR` and `TOG` return 0.
- **Input path:** each pin goes through a 2-flop synchroniser followed by a previous-value flop.
  - rise_i = `sync_i & ~prev_i`
  - fall_i = `~sync_i & prev_i`
- **`IN` readback:** `IN` returns the synchronised value even for pins configured as outputs, so software can read back the driven level.
- **Status update:** `ISR[i]` is set when (rise_i & `IER[i]`) | (fall_i & `IEF[i]`).
  - A write of 1 to `ISR[i]` clears it.
  - If a set and a clear land in the same cycle, the set wins.
- **Edge-detect arming:** edge detection is suppressed until an arm counter reaches 3 after reset deassertion. This prevents spurious edges from reset-value flops.
  - The counter is 2 bits and saturates at 3.
  - Pin changes during the unarmed window never set `ISR`.
- **Enables do not gate status clearing:** clearing `IER`/`IEF` leaves pending `ISR` bits set. `IRQ` = |(`ISR` & (`IER` | `IEF`)).
- **Simultaneous WE and RE:** both are honoured. The read returns the pre-write value.

## Timing
- **Reset values:** `OUT`=0, `DIR`=0 (all pins high-Z), `IER`=`IEF`=`ISR`=0, `RDATA`=0, `RVALID`=0, `IRQ`=0, synchroniser flops=0, arm counter=0.
- **Write pipeline:** bus request fields (`WE`, `RE`, offset, `WDATA`, hit) are registered at posedge N. The register update happens at posedge N+1. A pin change is therefore visible after posedge N+1.
- **Read pipeline:** `RDATA`/`RVALID` are valid in the cycle after posedge N+1, i.e. 2-cycle read latency. `RVALID` is high for exactly 1 cycle per read hit. `RDATA` holds its value otherwise.
- **Back-to-back accesses:** one access per cycle is supported, with no stall. A write at cycle N followed by a read of the same register at N+1 returns the new value.
- **Input-to-`IN` latency:** a pin change is visible in `IN` 2 posedges after the change.
- **Input-to-`IRQ` latency:** the pin change sets `ISR` at the 3rd posedge and `IRQ` rises at the 4th. `IRQ` is registered.
- **`IRQ` deassertion:** `IRQ` drops 1 cycle after the `ISR` clear takes effect.
- **Reset mid-operation:** pins go high-Z and all state returns to the reset values immediately, asynchronously. No pending write completes.

## Structure
- **Shared constants** go in the shared define header: the offset constants `GPIO_OFS_OUT`..`GPIO_OFS_ISR` (0..8) and the default base address.
- **Sub-module `gpio_edge`** (one instance per pin, via a generate loop):
  - contents: 2-flop synchroniser, previous-value flop, rise/fall outputs;
  - inputs: `CLK`, `RST_X`;
  - output: an arm-qualified rise/fall pair.
- **Top level** holds the request pipeline, the register file, the read mux, the arm counter and the tri-state drivers.

## Test plan
- **Direction and output:** after reset, write `DIR`=16'h00FF, then `OUT`=16'hA5A5.
  - `GPIO[7:0]`=8'hA5 and `GPIO[15:8]`=Z, observed after posedge N+1.
  - Reading `OUT` returns 16'hA5A5 with `RVALID` high 2 cycles after `RE`.
- **Set/clear/toggle:** with `OUT`=16'h00F0, write `SET` 16'h0003, then `CLR` 16'h0010, then `TOG` 16'hFFFF.
  - `OUT` ends at 16'hFF1C.
  - Reads of offsets 3, 4 and 5 return 0.
- **Rising-edge interrupt:** `IER`=16'h0004, `DIR`=0; drive `GPIO[2]` 0→1.
  - `ISR` reads 16'h0004 and `IRQ` rises 4 cycles after the edge.
  - Writing `ISR`=16'h0004 drops `IRQ` 2 cycles after the write posedge.
- **Clear/set collision:** `IEF`=16'h0001; time a falling edge on `GPIO[0]` so that its `ISR` set coincides with a W1C write of 16'h0001.
  - `ISR[0]` remains 1 and `IRQ` stays high.
- **Reset suppression:** hold `GPIO`=16'hFFFF with `IER`/`IEF` all-ones, and pulse `RST_X` low for 2 cycles.
  - After release and re-enable, no `ISR` bit sets without a real edge.
  - An asynchronous reset mid-write leaves `OUT`=0 and `DIR`=0.
- **Parameter sweep:** `NPIN`=1 and `NPIN`=32 with `BASE`='h400000.
  - Address miss: `RVALID` stays low.
  - Hit at offset 2 returns pin levels.
  - Reserved offset 12 returns 0.

Source files
------------

// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank: register offsets, default base address
// and the edge-detect arm counter helpers.
package gpio_bank_pkg;

  // Register offsets within the 16-byte bank window.
  localparam logic [3:0] GPIO_OFS_OUT = 4'd0;
  localparam logic [3:0] GPIO_OFS_DIR = 4'd1;
  localparam logic [3:0] GPIO_OFS_IN  = 4'd2;
  localparam logic [3:0] GPIO_OFS_SET = 4'd3;
  localparam logic [3:0] GPIO_OFS_CLR = 4'd4;
  localparam logic [3:0] GPIO_OFS_TOG = 4'd5;
  localparam logic [3:0] GPIO_OFS_IER = 4'd6;
  localparam logic [3:0] GPIO_OFS_IEF = 4'd7;
  localparam logic [3:0] GPIO_OFS_ISR = 4'd8;

  localparam logic [31:0] GPIO_DEFAULT_BASE = 32'h0080_01f0;

  // Edge detection stays off until the counter saturates, so the reset-value
  // synchroniser flops cannot fake an edge.
  typedef logic [1:0] arm_cnt_t;
  localparam arm_cnt_t ARM_DONE = 2'd3;

  function automatic arm_cnt_t arm_next(input arm_cnt_t cnt);
    return (cnt == ARM_DONE) ? ARM_DONE : cnt + 2'd1;
  endfunction

endpackage

// File: rtl/gpio_edge.sv
// Per-pin input path: two-flop synchroniser, previous-value flop and
// arm-qualified rise/fall detection.
module gpio_edge (
  input  logic CLK,
  input  logic RST_X,
  input  logic ARM,
  input  logic PIN,
  output logic SYNC,
  output logic RISE,
  output logic FALL
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronise the asynchronous pin and keep one cycle of history.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= PIN;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign SYNC = sync_q;
  assign RISE = ARM & sync_q & ~prev_q;
  assign FALL = ARM & ~sync_q & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: registered bus request, register file with
// set/clear/toggle writes, synchronised input readback and edge interrupts.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int unsigned NPIN = 16,
  parameter int unsigned AW   = 32,
  parameter logic [AW-1:0] BASE = AW'(GPIO_DEFAULT_BASE)
) (
  input  logic            CLK,
  input  logic            RST_X,
  input  logic            WE,
  input  logic            RE,
  input  logic [AW-1:0]   ADDR,
  input  logic [NPIN-1:0] WDATA,
  output logic [NPIN-1:0] RDATA,
  output logic            RVALID,
  output logic            IRQ,
  inout  wire  [NPIN-1:0] GPIO
);

  // Registered bus request
  logic            req_we_q;
  logic            req_re_q;
  logic            req_hit_q;
  logic [3:0]      req_ofs_q;
  logic [NPIN-1:0] req_wdata_q;

  // Register file
  logic [NPIN-1:0] out_q, out_d;
  logic [NPIN-1:0] dir_q, dir_d;
  logic [NPIN-1:0] ier_q, ier_d;
  logic [NPIN-1:0] ief_q, ief_d;
  logic [NPIN-1:0] isr_q, isr_d;

  logic [NPIN-1:0] rdata_q;
  logic            rvalid_q;
  logic            irq_q;
  arm_cnt_t        arm_q;

  logic [NPIN-1:0] pin_sync;
  logic [NPIN-1:0] pin_rise;
  logic [NPIN-1:0] pin_fall;
  logic [NPIN-1:0] rd_mux;
  logic            hit;
  logic            wr_en;
  logic            rd_en;
  logic            armed;

  assign hit   = (ADDR[AW-1:4] == BASE[AW-1:4]);
  assign wr_en = req_we_q & req_hit_q;
  assign rd_en = req_re_q & req_hit_q;
  assign armed = (arm_q == ARM_DONE);

  // Capture the bus request; it is acted on one cycle later.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      req_we_q    <= 1'b0;
      req_re_q    <= 1'b0;
      req_hit_q   <= 1'b0;
      req_ofs_q   <= 4'd0;
      req_wdata_q <= '0;
    end else begin
      req_we_q    <= WE;
      req_re_q    <= RE;
      req_hit_q   <= hit;
      req_ofs_q   <= ADDR[3:0];
      req_wdata_q <= WDATA;
    end
  end

  // Arm counter: counts up after reset release and saturates.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      arm_q <= '0;
    end else begin
      arm_q <= arm_next(arm_q);
    end
  end

  for (genvar i = 0; i < NPIN; i++) begin : g_pin
    gpio_edge u_edge (
      .CLK   (CLK),
      .RST_X (RST_X),
      .ARM   (armed),
      .PIN   (GPIO[i]),
      .SYNC  (pin_sync[i]),
      .RISE  (pin_rise[i]),
      .FALL  (pin_fall[i])
    );

    assign GPIO[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  // Next-state for the register file; a new edge beats a same-cycle W1C.
  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    ier_d = ier_q;
    ief_d = ief_q;
    isr_d = isr_q;
    if (wr_en) begin
      case (req_ofs_q)
        GPIO_OFS_OUT: out_d = req_wdata_q;
        GPIO_OFS_DIR: dir_d = req_wdata_q;
        GPIO_OFS_SET: out_d = out_q | req_wdata_q;
        GPIO_OFS_CLR: out_d = out_q & ~req_wdata_q;
        GPIO_OFS_TOG: out_d = out_q ^ req_wdata_q;
        GPIO_OFS_IER: ier_d = req_wdata_q;
        GPIO_OFS_IEF: ief_d = req_wdata_q;
        GPIO_OFS_ISR: isr_d = isr_q & ~req_wdata_q;
        default:      ;
      endcase
    end
    isr_d = isr_d | (pin_rise & ier_q) | (pin_fall & ief_q);
  end

  // Register file state.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      out_q <= '0;
      dir_q <= '0;
      ier_q <= '0;
      ief_q <= '0;
      isr_q <= '0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
      ier_q <= ier_d;
      ief_q <= ief_d;
      isr_q <= isr_d;
    end
  end

  // Read mux over current (pre-write) register values; write-only and
  // reserved offsets read as zero.
  always_comb begin
    rd_mux = '0;
    case (req_ofs_q)
      GPIO_OFS_OUT: rd_mux = out_q;
      GPIO_OFS_DIR: rd_mux = dir_q;
      GPIO_OFS_IN:  rd_mux = pin_sync;
      GPIO_OFS_IER: rd_mux = ier_q;
      GPIO_OFS_IEF: rd_mux = ief_q;
      GPIO_OFS_ISR: rd_mux = isr_q;
      default:      rd_mux = '0;
    endcase
  end

  // Registered read response and interrupt; RDATA holds between reads.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) begin
        rdata_q <= rd_mux;
      end
      irq_q <= |(isr_q & (ier_q | ief_q));
    end
  end

  assign RDATA  = rdata_q;
  assign RVALID = rvalid_q;
  assign IRQ    = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: main 16-pin instance plus 1- and 32-pin
// instances at a different base address.
module tb_gpio_bank;
  import gpio_bank_pkg::*;

  localparam logic [31:0] MAIN_BASE  = 32'h0080_01f0;
  localparam logic [31:0] SWEEP_BASE = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst_x;

  // Main instance bus
  logic        we;
  logic        re;
  logic [31:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rvalid;
  logic        irq;
  wire  [15:0] gpio;
  logic [15:0] tb_oe;
  logic [15:0] tb_drv;

  // Sweep instances share one bus
  logic        s_we;
  logic        s_re;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_oe;
  logic [0:0]  rdata1;
  logic        rvalid1;
  logic        irq1;
  wire  [0:0]  gpio1;
  logic [31:0] rdata32;
  logic        rvalid32;
  logic        irq32;
  wire  [31:0] gpio32;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 16; i++) begin : g_drv
    assign gpio[i] = tb_oe[i] ? tb_drv[i] : 1'bz;
  end
  assign gpio1  = s_oe ? 1'b1 : 1'bz;
  assign gpio32 = s_oe ? 32'hDEAD_BEEF : 32'hz;

  gpio_bank #(.NPIN(16), .AW(32), .BASE(MAIN_BASE)) u_dut (
    .CLK(clk), .RST_X(rst_x), .WE(we), .RE(re), .ADDR(addr), .WDATA(wdata),
    .RDATA(rdata), .RVALID(rvalid), .IRQ(irq), .GPIO(gpio)
  );

  gpio_bank #(.NPIN(1), .AW(32), .BASE(SWEEP_BASE)) u_dut1 (
    .CLK(clk), .RST_X(rst_x), .WE(s_we), .RE(s_re), .ADDR(s_addr), .WDATA(s_wdata[0:0]),
    .RDATA(rdata1), .RVALID(rvalid1), .IRQ(irq1), .GPIO(gpio1)
  );

  gpio_bank #(.NPIN(32), .AW(32), .BASE(SWEEP_BASE)) u_dut32 (
    .CLK(clk), .RST_X(rst_x), .WE(s_we), .RE(s_re), .ADDR(s_addr), .WDATA(s_wdata),
    .RDATA(rdata32), .RVALID(rvalid32), .IRQ(irq32), .GPIO(gpio32)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [3:0] ofs, input logic [15:0] d);
    @(negedge clk);
    we    = 1'b1;
    addr  = MAIN_BASE | {28'h0, ofs};
    wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Request at posedge N, response sampled on the negedge after N+1.
  task automatic read_check(input string tag, input logic [3:0] ofs, input logic [15:0] exp);
    @(negedge clk);
    re   = 1'b1;
    addr = MAIN_BASE | {28'h0, ofs};
    @(negedge clk);
    re = 1'b0;
    @(negedge clk);
    check_eq({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check_eq(tag, 32'(rdata), 32'(exp));
  endtask

  task automatic sweep_read(input logic [31:0] a, output logic v1, output logic [0:0] d1,
                            output logic v32, output logic [31:0] d32);
    @(negedge clk);
    s_re   = 1'b1;
    s_addr = a;
    @(negedge clk);
    s_re = 1'b0;
    @(negedge clk);
    v1  = rvalid1;
    d1  = rdata1;
    v32 = rvalid32;
    d32 = rdata32;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        v1, v32;
    logic [0:0]  d1;
    logic [31:0] d32;

    rst_x = 1'b0;  we = 1'b0;  re = 1'b0;  addr = '0;  wdata = '0;
    tb_oe = 16'h0;  tb_drv = 16'h0;
    s_we = 1'b0;  s_re = 1'b0;  s_addr = '0;  s_wdata = '0;  s_oe = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_rdata", 32'(rdata), 32'd0);
    rst_x = 1'b1;
    read_check("rst_out", GPIO_OFS_OUT, 16'h0);
    read_check("rst_dir", GPIO_OFS_DIR, 16'h0);
    read_check("rst_isr", GPIO_OFS_ISR, 16'h0);

    // Direction and output; the bench drives the upper (input) byte.
    tb_oe  = 16'hFF00;
    tb_drv = 16'h3C00;
    bus_write(GPIO_OFS_DIR, 16'h00FF);
    bus_write(GPIO_OFS_OUT, 16'hA5A5);
    check_eq("pin_before_n1", 32'(gpio[7:0]), 32'h00);
    @(posedge clk); #1;
    check_eq("pin_after_n1", 32'(gpio[7:0]), 32'hA5);
    check_eq("pin_hi_input", 32'(gpio[15:8]), 32'h3C);
    read_check("out_a5a5", GPIO_OFS_OUT, 16'hA5A5);
    @(negedge clk);
    check_eq("rvalid_pulse", 32'(rvalid), 32'd0);
    read_check("dir_00ff", GPIO_OFS_DIR, 16'h00FF);
    read_check("in_mixed", GPIO_OFS_IN, 16'h3CA5);

    // Set / clear / toggle
    bus_write(GPIO_OFS_OUT, 16'h00F0);
    bus_write(GPIO_OFS_SET, 16'h0003);
    bus_write(GPIO_OFS_CLR, 16'h0010);
    bus_write(GPIO_OFS_TOG, 16'hFFFF);
    read_check("out_ff1c", GPIO_OFS_OUT, 16'hFF1C);
    check_eq("pin_1c", 32'(gpio[7:0]), 32'h1C);
    read_check("rd_set", GPIO_OFS_SET, 16'h0);
    read_check("rd_clr", GPIO_OFS_CLR, 16'h0);
    read_check("rd_tog", GPIO_OFS_TOG, 16'h0);
    read_check("rd_rsvd12", 4'd12, 16'h0);

    // All pins become inputs; bit 0 starts high for the later falling edge.
    bus_write(GPIO_OFS_DIR, 16'h0000);
    @(posedge clk); #1;
    tb_oe  = 16'hFFFF;
    tb_drv = 16'h0001;

    // Rising-edge interrupt on pin 2
    bus_write(GPIO_OFS_IER, 16'h0004);
    repeat (4) @(negedge clk);
    check_eq("irq_idle", 32'(irq), 32'd0);
    @(negedge clk);
    tb_drv[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("irq_edge_p3", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check_eq("irq_edge_p4", 32'(irq), 32'd1);
    read_check("isr_rise", GPIO_OFS_ISR, 16'h0004);
    bus_write(GPIO_OFS_ISR, 16'h0004);
    @(posedge clk); #1;
    check_eq("irq_w1c_n1", 32'(irq), 32'd1);
    @(posedge clk); #1;
    check_eq("irq_w1c_n2", 32'(irq), 32'd0);
    read_check("isr_cleared", GPIO_OFS_ISR, 16'h0);

    // Set/clear collision on pin 0: falling edge sets ISR on the same
    // posedge the W1C write lands.
    bus_write(GPIO_OFS_IEF, 16'h0001);
    repeat (3) @(negedge clk);
    @(negedge clk);
    tb_drv[0] = 1'b0;
    bus_write(GPIO_OFS_ISR, 16'h0001);
    @(posedge clk);
    @(posedge clk); #1;
    check_eq("irq_collide", 32'(irq), 32'd1);
    read_check("isr_collide", GPIO_OFS_ISR, 16'h0001);
    bus_write(GPIO_OFS_ISR, 16'h0001);
    read_check("isr_collide_clr", GPIO_OFS_ISR, 16'h0);

    // Reset suppression with all pins high and all enables set
    tb_drv = 16'hFFFF;
    bus_write(GPIO_OFS_IER, 16'hFFFF);
    bus_write(GPIO_OFS_IEF, 16'hFFFF);
    repeat (4) @(negedge clk);
    @(negedge clk);
    we    = 1'b1;
    addr  = MAIN_BASE | {28'h0, GPIO_OFS_OUT};
    wdata = 16'h1234;
    @(posedge clk); #2;
    rst_x = 1'b0;
    we    = 1'b0;
    #1;
    check_eq("rst_mid_irq", 32'(irq), 32'd0);
    check_eq("rst_mid_rvalid", 32'(rvalid), 32'd0);
    repeat (2) @(negedge clk);
    // Re-enable IER straight out of reset so it is live before arming ends.
    rst_x = 1'b1;
    we    = 1'b1;
    addr  = MAIN_BASE | {28'h0, GPIO_OFS_IER};
    wdata = 16'hFFFF;
    @(negedge clk);
    we = 1'b0;
    bus_write(GPIO_OFS_IEF, 16'hFFFF);
    repeat (6) @(negedge clk);
    read_check("isr_no_spurious", GPIO_OFS_ISR, 16'h0);
    check_eq("irq_no_spurious", 32'(irq), 32'd0);
    read_check("out_after_rst", GPIO_OFS_OUT, 16'h0);
    read_check("dir_after_rst", GPIO_OFS_DIR, 16'h0);
    read_check("in_all_high", GPIO_OFS_IN, 16'hFFFF);
    @(negedge clk);
    tb_drv[5] = 1'b0;
    repeat (5) @(negedge clk);
    read_check("isr_real_fall", GPIO_OFS_ISR, 16'h0020);
    check_eq("irq_real_fall", 32'(irq), 32'd1);

    // Parameter sweep: NPIN=1 and NPIN=32 at another base
    sweep_read(SWEEP_BASE + 32'h12, v1, d1, v32, d32);
    check_eq("sw1_miss_rvalid", 32'(v1), 32'd0);
    check_eq("sw32_miss_rvalid", 32'(v32), 32'd0);
    sweep_read(SWEEP_BASE + 32'h2, v1, d1, v32, d32);
    check_eq("sw1_in_rvalid", 32'(v1), 32'd1);
    check_eq("sw1_in", 32'(d1), 32'd1);
    check_eq("sw32_in_rvalid", 32'(v32), 32'd1);
    check_eq("sw32_in", d32, 32'hDEAD_BEEF);
    sweep_read(SWEEP_BASE + 32'hC, v1, d1, v32, d32);
    check_eq("sw1_rsvd_rvalid", 32'(v1), 32'd1);
    check_eq("sw1_rsvd", 32'(d1), 32'd0);
    check_eq("sw32_rsvd_rvalid", 32'(v32), 32'd1);
    check_eq("sw32_rsvd", d32, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
